delta_spike_event_fifo: RTL
===========================

Name: delta_spike_event_fifo

Overview:
- Downstream consumer of the delta-modulation spike encoder's 2-bit spike output.
- Timestamps every up or down spike and packs it into an event word of {polarity, timestamp}.
- Buffers events in a small show-ahead FIFO and presents them on a valid/ready interface to the host-side readout logic.
- Tracks overflow, dropped events and illegal spike codes.

Parameters:
- TS_WIDTH, 6: timestamp counter width in bits. The event word is TS_WIDTH+1 bits.
- DEPTH, 4: number of FIFO entries. Must be a power of 2 and at least 2.
- DROP_WIDTH, 4: width of the saturating dropped-event counter.

Ports:
- clk  in  1: clock. All state updates on the rising edge.
- reset  in  1: synchronous, active-high reset.
- en  in  1: capture enable. When 0, the timestamp holds and spikes are ignored.
- spike  in  2: encoder output. 2'b01 = up spike, 2'b10 = down spike, 2'b00 = none, 2'b11 = illegal.
- clr  in  1: synchronous clear of drop_count, overflow and bad_spike.
- ev_data  out  TS_WIDTH+1: head event. Bit TS_WIDTH is polarity (1 = up, 0 = down); the low bits are the timestamp.
- ev_valid  out  1: FIFO non-empty; ev_data is valid.
- ev_ready  in  1: consumer accepts the head event when ev_valid and ev_ready are both high at a clock edge.
- fifo_count  out  $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- overflow  out  1: sticky. Set when an event is dropped.
- drop_count  out  DROP_WIDTH: number of dropped events, saturating at all-ones.
- bad_spike  out  1: sticky. Set when spike==2'b11 is sampled while en=1.

Behaviour:
- Reset (synchronous, highest priority): ts, read pointer, write pointer, fifo_count, drop_count, overflow and bad_spike all go to 0. ev_valid=0. ev_data is don't-care while ev_valid=0, but RTL drives the memory head value.
- Timestamp ts:
  - Increments by 1 each cycle while en=1.
  - Wraps from 2^TS_WIDTH-1 to 0 with no flag.
  - Holds while en=0.
- An event carries the ts value before the increment at that edge. Two spikes on consecutive enabled cycles therefore differ by exactly 1.
- Push request: en=1 and spike is 2'b01 or 2'b10.
  - Written word: {spike==2'b01, ts}.
- Pop: ev_valid & ev_ready at the edge.
- Latency: a spike sampled at edge N into an empty FIFO gives ev_valid=1 and ev_data=event after edge N, i.e. one cycle of latency. There is no fall-through within the same cycle.
- Show-ahead: ev_data is the memory entry at the read pointer. It only changes after a pop or after a write into an empty FIFO.
- ev_valid = (fifo_count != 0). It is registered-equivalent and never depends combinationally on ev_ready or spike.
- Push when not full: the entry is written and fifo_count increments, unless a pop happens in the same edge, in which case the count is unchanged.
- Push when full:
  - With a simultaneous pop, the push is accepted. The freed slot is reused, the count stays DEPTH, and nothing is dropped.
  - Without a pop, the event is dropped: overflow<=1 and drop_count increments with saturation. FIFO contents are unchanged.
- Pop when empty: impossible, because ev_valid=0. ev_ready is ignored.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full and empty are derived from fifo_count.
- spike==2'b11 with en=1: no push, bad_spike<=1, ts still increments.
- clr: drop_count<=0, overflow<=0, bad_spike<=0. If a drop or bad spike occurs in the same cycle, the new event wins: drop_count<=1, overflow<=1, or bad_spike<=1 respectively. clr never touches FIFO contents or ts.
- Reset mid-operation discards all buffered events; the first post-reset event has ts=0.
- ev_ready may toggle freely. The consumer may hold ev_ready=1 permanently, which gives one event per cycle of throughput.

Test Plan:
- Reset, then en=1 and spike=01 at the first enabled edge (ts=0) with ev_ready=0 -> next cycle ev_valid=1, ev_data=7'b1_000000, fifo_count=1.
- en=1, spikes 01, 10, 01 on the cycles with ts=5, 6, 7 and ev_ready=0 -> pops in order return 0x45, 0x06, 0x47. fifo_count goes 3, 2, 1, 0.
- FIFO full (4 entries), ev_ready=0, two more up spikes -> fifo_count=4, overflow=1, drop_count=2, the original 4 events are intact. With DROP_WIDTH=4, 20 drops -> drop_count=15.
- FIFO full with spike=10 and ev_ready=1 in the same cycle -> no drop, fifo_count stays 4, the tail entry is the new event, and the head advances.
- en=0 with spike=01 for 3 cycles -> no push and ts frozen. Then en=1 with spike=11 -> bad_spike=1 and no push. Then clr together with a full-FIFO drop -> drop_count=1, overflow=1, bad_spike=0.
- Run ts across the wrap (spike at ts=63 and at the next cycle) -> events carry ts 63 then 0. Reset asserted with 3 events buffered -> next cycle fifo_count=0, ev_valid=0.

Source files
------------

// File: rtl/delta_spike_event_fifo.sv
// delta_spike_event_fifo
// Timestamps up/down spikes from the delta-modulation encoder, packs them as
// {polarity, timestamp} event words and buffers them in a show-ahead FIFO that
// is read over a valid/ready handshake. Overflow, dropped events and illegal
// spike codes are tracked in sticky status registers.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   en         in   capture enable (timestamp runs, spikes accepted)
//   spike      in   2'b01 up, 2'b10 down, 2'b00 none, 2'b11 illegal
//   clr        in   synchronous clear of drop_count / overflow / bad_spike
//   ev_data    out  head event {polarity, timestamp}
//   ev_valid   out  FIFO non-empty
//   ev_ready   in   consumer accepts head when ev_valid & ev_ready
//   fifo_count out  occupancy 0..DEPTH
//   overflow   out  sticky, set on a dropped event
//   drop_count out  saturating dropped-event count
//   bad_spike  out  sticky, set on spike==2'b11 while enabled
module delta_spike_event_fifo #(
  parameter int TS_WIDTH   = 6,
  parameter int DEPTH      = 4,
  parameter int DROP_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [1:0]                 spike,
  input  logic                       clr,
  output logic [TS_WIDTH:0]          ev_data,
  output logic                       ev_valid,
  input  logic                       ev_ready,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow,
  output logic [DROP_WIDTH-1:0]      drop_count,
  output logic                       bad_spike
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int EV_W  = TS_WIDTH + 1;

  localparam logic [1:0]            SPK_UP   = 2'b01;
  localparam logic [1:0]            SPK_DOWN = 2'b10;
  localparam logic [1:0]            SPK_BAD  = 2'b11;
  localparam logic [CNT_W-1:0]      CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0]      PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [TS_WIDTH-1:0]   TS_ONE   = {{(TS_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DROP_WIDTH-1:0] DROP_ONE = {{(DROP_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DROP_WIDTH-1:0] DROP_MAX = {DROP_WIDTH{1'b1}};

  logic [EV_W-1:0]       mem_r [DEPTH];
  logic [TS_WIDTH-1:0]   ts_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic                  ev_valid_r;
  logic                  overflow_r;
  logic [DROP_WIDTH-1:0] drop_count_r;
  logic                  bad_spike_r;

  logic                  push_req_s;
  logic                  pop_s;
  logic                  full_s;
  logic                  push_ok_s;
  logic                  drop_s;
  logic                  bad_s;
  logic [EV_W-1:0]       word_s;
  logic [CNT_W-1:0]      count_next_s;

  // Push/pop/drop decode and next occupancy.
  always_comb begin
    push_req_s   = en && ((spike == SPK_UP) || (spike == SPK_DOWN));
    bad_s        = en && (spike == SPK_BAD);
    pop_s        = ev_valid_r && ev_ready;
    full_s       = (count_r == CNT_FULL);
    // A push into a full FIFO still lands if the head leaves on the same edge.
    push_ok_s    = push_req_s && (!full_s || pop_s);
    drop_s       = push_req_s && full_s && !pop_s;
    word_s       = {(spike == SPK_UP), ts_r};
    count_next_s = count_r;
    case ({push_ok_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // Event storage; contents are never cleared, only overwritten on push.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= word_s;
    end
  end

  // Timestamp, pointers, occupancy and registered valid flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      ts_r       <= {TS_WIDTH{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      wr_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      ev_valid_r <= 1'b0;
    end else begin
      if (en) begin
        ts_r <= ts_r + TS_ONE;
      end
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r    <= count_next_s;
      ev_valid_r <= (count_next_s != {CNT_W{1'b0}});
    end
  end

  // Sticky status; a same-cycle event takes precedence over clr.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_r   <= 1'b0;
      drop_count_r <= {DROP_WIDTH{1'b0}};
      bad_spike_r  <= 1'b0;
    end else if (clr) begin
      overflow_r   <= drop_s;
      drop_count_r <= drop_s ? DROP_ONE : {DROP_WIDTH{1'b0}};
      bad_spike_r  <= bad_s;
    end else begin
      if (drop_s) begin
        overflow_r <= 1'b1;
        if (drop_count_r != DROP_MAX) begin
          drop_count_r <= drop_count_r + DROP_ONE;
        end
      end
      if (bad_s) begin
        bad_spike_r <= 1'b1;
      end
    end
  end

  assign ev_data    = mem_r[rd_ptr_r];
  assign ev_valid   = ev_valid_r;
  assign fifo_count = count_r;
  assign overflow   = overflow_r;
  assign drop_count = drop_count_r;
  assign bad_spike  = bad_spike_r;

endmodule
